// File: rtl/avalon_csr_pkg.sv
// Shared address-map helpers for the Avalon-MM CSR bank.
// Offsets are derived from the RW/RO register counts of each instance.
package avalon_csr_pkg;

  function automatic int irq_status_ofs(input int n_rw, input int n_ro);
    return n_rw + n_ro;
  endfunction

  function automatic int irq_enable_ofs(input int n_rw, input int n_ro);
    return n_rw + n_ro + 1;
  endfunction

  function automatic int commit_ofs(input int n_rw, input int n_ro);
    return n_rw + n_ro + 2;
  endfunction

  // Byte address to 32-bit word index.
  function automatic int word_idx(input logic [31:0] addr);
    return int'(addr >> 2);
  endfunction

endpackage

// File: rtl/avalon_csr_irq.sv
// Sticky interrupt block: W1C status, RW enable and registered irq output.
module avalon_csr_irq #(
  parameter int N_IRQ = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_event,
  input  logic             status_wr,
  input  logic             enable_wr,
  input  logic [N_IRQ-1:0] wr_data,
  input  logic [N_IRQ-1:0] wr_mask,
  output logic [N_IRQ-1:0] irq_status,
  output logic [N_IRQ-1:0] irq_enable,
  output logic             irq
);

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_status <= '0;
      irq_enable <= '0;
      irq        <= 1'b0;
    end else begin
      // OR-ing the event in after the clear makes a same-cycle set win.
      if (status_wr)
        irq_status <= (irq_status & ~(wr_data & wr_mask)) | irq_event;
      else
        irq_status <= irq_status | irq_event;
      if (enable_wr)
        irq_enable <= (irq_enable & ~wr_mask) | (wr_data & wr_mask);
      irq <= |(irq_status & irq_enable);
    end
  end

endmodule

// File: rtl/avalon_csr_bank.sv
// Avalon-MM slave CSR bank: byte-enabled RW regs, RO inputs, sticky IRQ block,
// READ_LAT-deep read pipeline. Define CSR_SHADOW_EN for shadowed RW regs + COMMIT.
module avalon_csr_bank
  import avalon_csr_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 10,
  parameter int N_RW     = 8,
  parameter int N_RO     = 4,
  parameter int N_IRQ    = 8,
  parameter int READ_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      mm_address,
  input  logic                   mm_write,
  input  logic [DATA_W-1:0]      mm_writedata,
  input  logic [DATA_W/8-1:0]    mm_byteenable,
  input  logic                   mm_read,
  output logic [DATA_W-1:0]      mm_readdata,
  output logic                   mm_readdatavalid,
  output logic                   mm_waitrequest,
  output logic [N_RW*DATA_W-1:0] rw_regs,
  output logic [N_RW-1:0]        rw_wr_strobe,
  input  logic [N_RO*DATA_W-1:0] ro_regs,
  input  logic [N_IRQ-1:0]       irq_event,
  output logic                   irq
);

  localparam int BE_W           = DATA_W / 8;
  localparam int STAGES         = READ_LAT - 1;
  localparam int IRQ_STATUS_OFS = irq_status_ofs(N_RW, N_RO);
  localparam int IRQ_ENABLE_OFS = irq_enable_ofs(N_RW, N_RO);

  int                            widx;
  logic                          wr_any;
  logic [DATA_W-1:0]             wmask;
  logic [N_RW-1:0]               wr_rw;
  logic [N_RW-1:0][DATA_W-1:0]   rw_q;
  logic [N_IRQ-1:0]              irq_status, irq_enable;
  logic [DATA_W-1:0]             rd_data;
  logic [STAGES:0]               vld_pipe;
  logic [STAGES:0][DATA_W-1:0]   dat_pipe;

  assign mm_waitrequest = 1'b0;
  assign widx   = word_idx(32'(mm_address));
  // A write with no byte enabled is a no-op: no update, no strobe.
  assign wr_any = mm_write && (|mm_byteenable);

  for (genvar b = 0; b < BE_W; b++) begin : g_mask
    assign wmask[b*8 +: 8] = {8{mm_byteenable[b]}};
  end

  for (genvar k = 0; k < N_RW; k++) begin : g_wsel
    assign wr_rw[k] = wr_any && (widx == k);
  end

  // rw_q is the software-visible copy: the live regs, or the shadows when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      rw_q <= '0;
    end else begin
      for (int k = 0; k < N_RW; k++)
        if (wr_rw[k]) rw_q[k] <= (rw_q[k] & ~wmask) | (mm_writedata & wmask);
    end
  end

`ifdef CSR_SHADOW_EN
  localparam int COMMIT_OFS = commit_ofs(N_RW, N_RO);

  logic                        commit;
  logic [N_RW-1:0][DATA_W-1:0] rw_live;

  assign commit = wr_any && (widx == COMMIT_OFS) && mm_byteenable[0] && mm_writedata[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      rw_live      <= '0;
      rw_wr_strobe <= '0;
    end else begin
      if (commit) rw_live <= rw_q;
      rw_wr_strobe <= {N_RW{commit}};
    end
  end

  assign rw_regs = rw_live;
`else
  always_ff @(posedge clk) begin
    if (rst) rw_wr_strobe <= '0;
    else     rw_wr_strobe <= wr_rw;
  end

  assign rw_regs = rw_q;
`endif

  avalon_csr_irq #(.N_IRQ(N_IRQ)) u_irq (
    .clk        (clk),
    .rst        (rst),
    .irq_event  (irq_event),
    .status_wr  (wr_any && (widx == IRQ_STATUS_OFS)),
    .enable_wr  (wr_any && (widx == IRQ_ENABLE_OFS)),
    .wr_data    (mm_writedata[N_IRQ-1:0]),
    .wr_mask    (wmask[N_IRQ-1:0]),
    .irq_status (irq_status),
    .irq_enable (irq_enable),
    .irq        (irq)
  );

  // Read mux samples current state, so a same-cycle write is not visible.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < N_RW; k++)
      if (widx == k) rd_data = rw_q[k];
    for (int k = 0; k < N_RO; k++)
      if (widx == N_RW + k) rd_data = ro_regs[k*DATA_W +: DATA_W];
    if (widx == IRQ_STATUS_OFS) rd_data[N_IRQ-1:0] = irq_status;
    if (widx == IRQ_ENABLE_OFS) rd_data[N_IRQ-1:0] = irq_enable;
  end

  // Reset flushes in-flight reads along with everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= mm_read;
      dat_pipe[0] <= rd_data;
      for (int i = 1; i <= STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign mm_readdatavalid = vld_pipe[STAGES];
  assign mm_readdata      = dat_pipe[STAGES];

endmodule

// File: tb/tb_avalon_csr_bank.sv
// Directed self-checking bench for avalon_csr_bank (READ_LAT=2); honours CSR_SHADOW_EN.
module tb_avalon_csr_bank;

  localparam int DW = 32, AW = 10, NRW = 8, NRO = 4, NIRQ = 8, LAT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [AW-1:0]     mm_address;
  logic              mm_write;
  logic [DW-1:0]     mm_writedata;
  logic [DW/8-1:0]   mm_byteenable;
  logic              mm_read;
  logic [DW-1:0]     mm_readdata;
  logic              mm_readdatavalid;
  logic              mm_waitrequest;
  logic [NRW*DW-1:0] rw_regs;
  logic [NRW-1:0]    rw_wr_strobe;
  logic [NRO*DW-1:0] ro_regs;
  logic [NIRQ-1:0]   irq_event;
  logic              irq;

  int errs = 0, checks = 0;

  always #5 clk = ~clk;

  avalon_csr_bank #(
    .DATA_W(DW), .ADDR_W(AW), .N_RW(NRW), .N_RO(NRO), .N_IRQ(NIRQ), .READ_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst), .mm_address(mm_address), .mm_write(mm_write),
    .mm_writedata(mm_writedata), .mm_byteenable(mm_byteenable), .mm_read(mm_read),
    .mm_readdata(mm_readdata), .mm_readdatavalid(mm_readdatavalid),
    .mm_waitrequest(mm_waitrequest), .rw_regs(rw_regs), .rw_wr_strobe(rw_wr_strobe),
    .ro_regs(ro_regs), .irq_event(irq_event), .irq(irq)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    mm_address = a; mm_writedata = d; mm_byteenable = be; mm_write = 1'b1;
    tick();
    mm_write = 1'b0; mm_byteenable = '0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [31:0] exp, input string tag);
    mm_address = a; mm_read = 1'b1;
    tick();
    mm_read = 1'b0;
    for (int c = 1; c < LAT; c++) begin
      chk({tag, "_early"}, mm_readdatavalid, 1'b0);
      tick();
    end
    chk({tag, "_vld"}, mm_readdatavalid, 1'b1);
    chk({tag, "_data"}, mm_readdata, exp);
    tick();
    chk({tag, "_once"}, mm_readdatavalid, 1'b0);
  endtask

  initial begin
    rst = 1'b1; mm_address = '0; mm_write = 1'b0; mm_writedata = '0;
    mm_byteenable = '0; mm_read = 1'b0; irq_event = '0;
    ro_regs = {32'h0BAD0003, 32'h0BAD0002, 32'h0BAD0001, 32'h12345678};
    repeat (3) tick();

    // reset state
    chk("rst_rw", |rw_regs, 1'b0);
    chk("rst_strobe", rw_wr_strobe, 8'h00);
    chk("rst_vld", mm_readdatavalid, 1'b0);
    chk("rst_rdata", mm_readdata, 32'h0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_wait", mm_waitrequest, 1'b0);
    rst = 1'b0;
    rd(10'h000, 32'h00000000, "t1_rd0");

    // byte-enable merge and strobes
    wr(10'h008, 32'h11223344, 4'hF);
`ifdef CSR_SHADOW_EN
    chk("t2_stb_a", rw_wr_strobe, 8'h00);
`else
    chk("t2_stb_a", rw_wr_strobe, 8'h04);
`endif
    tick();
    chk("t2_stb_clr", rw_wr_strobe, 8'h00);
    wr(10'h008, 32'hDEADBEEF, 4'b0101);
`ifdef CSR_SHADOW_EN
    chk("t2_stb_b", rw_wr_strobe, 8'h00);
`else
    chk("t2_stb_b", rw_wr_strobe, 8'h04);
    chk("t2_rwout", rw_regs[2*DW +: DW], 32'h11AD33EF);
`endif
    rd(10'h008, 32'h11AD33EF, "t2_merge");
    wr(10'h008, 32'hFFFFFFFF, 4'h0);
    chk("t2_be0_stb", rw_wr_strobe, 8'h00);
    rd(10'h008, 32'h11AD33EF, "t2_be0");

    // same-cycle read and write to one index returns the old value
    mm_address = 10'h008; mm_writedata = 32'h0; mm_byteenable = 4'hF;
    mm_write = 1'b1; mm_read = 1'b1;
    tick();
    mm_write = 1'b0; mm_read = 1'b0; mm_byteenable = '0;
    tick();
    chk("t2_rw_vld", mm_readdatavalid, 1'b1);
    chk("t2_rw_old", mm_readdata, 32'h11AD33EF);
    rd(10'h008, 32'h00000000, "t2_rw_new");

    // back-to-back reads
    wr(10'h000, 32'hA0, 4'hF);
    wr(10'h004, 32'hA1, 4'hF);
    wr(10'h008, 32'hA2, 4'hF);
    wr(10'h00C, 32'hA3, 4'hF);
    for (int k = 1; k <= 7; k++) begin
      if (k <= 4) begin
        mm_read = 1'b1; mm_address = AW'((k - 1) * 4);
      end else begin
        mm_read = 1'b0;
      end
      tick();
      chk($sformatf("t3_vld%0d", k), mm_readdatavalid, (k >= 2 && k <= 5));
      if (k >= 2 && k <= 5)
        chk($sformatf("t3_data%0d", k), mm_readdata, 32'(32'hA0 + k - 2));
    end

    // sticky interrupt, W1C, set-wins
    wr(10'h034, 32'h08, 4'hF);
    irq_event = 8'h08;
    tick();
    irq_event = 8'h00;
    chk("t4_irq_lag", irq, 1'b0);
    tick();
    chk("t4_irq_on", irq, 1'b1);
    rd(10'h030, 32'h08, "t4_status");
    rd(10'h034, 32'h08, "t4_enable");
    irq_event = 8'h08; mm_address = 10'h030; mm_writedata = 32'h08;
    mm_byteenable = 4'hF; mm_write = 1'b1;
    tick();
    irq_event = 8'h00; mm_write = 1'b0; mm_byteenable = '0;
    rd(10'h030, 32'h08, "t4_setwins");
    chk("t4_irq_held", irq, 1'b1);
    wr(10'h030, 32'h08, 4'hF);
    tick();
    chk("t4_irq_off", irq, 1'b0);
    rd(10'h030, 32'h00, "t4_cleared");
    irq_event = 8'h21;
    tick();
    irq_event = 8'h00;
    wr(10'h030, 32'h01, 4'hF);
    rd(10'h030, 32'h20, "t4_partial");
    chk("t4_irq_masked", irq, 1'b0);

    // RO and unmapped writes are ignored
    wr(10'h020, 32'hFFFFFFFF, 4'hF);
    wr(10'h3FC, 32'hFFFFFFFF, 4'hF);
    rd(10'h020, 32'h12345678, "t5_ro0");
    rd(10'h024, 32'h0BAD0001, "t5_ro1");
    rd(10'h3FC, 32'h00000000, "t5_unmapped");
    rd(10'h000, 32'hA0, "t5_rw0");
    rd(10'h034, 32'h08, "t5_en");

`ifdef CSR_SHADOW_EN
    // shadow + commit
    chk("t6_pre", rw_regs[1*DW +: DW], 32'h0);
    wr(10'h004, 32'h5, 4'hF);
    chk("t6_shadow_only", rw_regs[1*DW +: DW], 32'h0);
    rd(10'h004, 32'h5, "t6_shadow_rd");
    wr(10'h038, 32'h1, 4'hF);
    chk("t6_commit_w1", rw_regs[1*DW +: DW], 32'h5);
    chk("t6_commit_w0", rw_regs[0 +: DW], 32'hA0);
    chk("t6_stb_all", rw_wr_strobe, 8'hFF);
    tick();
    chk("t6_stb_clr", rw_wr_strobe, 8'h00);
`else
    chk("t5_rwout", rw_regs[0 +: DW], 32'hA0);
    wr(10'h038, 32'h1, 4'hF);
    chk("t6_commit_stb", rw_wr_strobe, 8'h00);
    rd(10'h038, 32'h0, "t6_commit_rd");
`endif

    // reset during an in-flight read drops it
    mm_address = 10'h000; mm_read = 1'b1;
    tick();
    mm_read = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t7_drop_a", mm_readdatavalid, 1'b0);
    tick();
    chk("t7_drop_b", mm_readdatavalid, 1'b0);
    chk("t7_rw_clr", |rw_regs, 1'b0);
    rd(10'h034, 32'h0, "t7_en_clr");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
